// File: rtl/flash_bus_arbiter_if.sv
// Pin bundle between the flash engines, the arbiter and the FPGA flash I/O.
// The arbiter takes the slave view; the engines and pad side take the master view.
interface flash_bus_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  done;
  logic [2:0]  gnt;
  logic [74:0] m_A;
  logic [47:0] m_dq_o;
  logic [2:0]  m_dqe;
  logic [2:0]  m_oe;
  logic [2:0]  m_ce;
  logic [2:0]  m_we;
  logic [2:0]  m_adv;
  logic [2:0]  m_wp;
  logic [2:0]  m_rst_f;
  logic [24:0] F_A;
  logic [15:0] F_dq_o;
  logic        F_dqe;
  logic        F_oe;
  logic        F_ce;
  logic        F_we;
  logic        F_adv;
  logic        F_wp;
  logic        F_rst_f;
  logic [15:0] F_dq_i;
  logic [15:0] dq_i;
  logic        busy;
  logic        to_pulse;
  logic        to_sts;

  modport slave (
    input  req, done, m_A, m_dq_o, m_dqe, m_oe, m_ce, m_we, m_adv, m_wp, m_rst_f, F_dq_i,
    output gnt, F_A, F_dq_o, F_dqe, F_oe, F_ce, F_we, F_adv, F_wp, F_rst_f, dq_i,
           busy, to_pulse, to_sts
  );

  modport master (
    output req, done, m_A, m_dq_o, m_dqe, m_oe, m_ce, m_we, m_adv, m_wp, m_rst_f, F_dq_i,
    input  gnt, F_A, F_dq_o, F_dqe, F_oe, F_ce, F_we, F_adv, F_wp, F_rst_f, dq_i,
           busy, to_pulse, to_sts
  );
endinterface

// File: rtl/flash_bus_arbiter.sv
// Round-robin owner of the NOR flash pins for erase/program/read engines, with
// a registered pin stage, a turnaround gap between owners and a hold watchdog.
module flash_bus_arbiter #(
  parameter int unsigned TURN    = 2,
  parameter logic [23:0] TIMEOUT = 24'd10000000
) (
  input logic                 clk,
  input logic                 rst_n,
  flash_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RELEASE} state_t;

  typedef struct packed {
    logic [24:0] a;
    logic [15:0] dq_o;
    logic        dqe;
    logic        oe;
    logic        ce;
    logic        we;
    logic        adv;
    logic        wp;
    logic        rst_f;
  } pins_t;

  localparam pins_t PINS_IDLE  = '{a: '0, dq_o: '0, dqe: 1'b0, oe: 1'b1, ce: 1'b1,
                                   we: 1'b1, adv: 1'b1, wp: 1'b1, rst_f: 1'b1};
  // Flash is held in reset and write-protected while rst_n is low.
  localparam pins_t PINS_RESET = '{a: '0, dq_o: '0, dqe: 1'b0, oe: 1'b1, ce: 1'b1,
                                   we: 1'b1, adv: 1'b1, wp: 1'b0, rst_f: 1'b0};
  localparam logic [3:0]  TURN_LAST = 4'(TURN - 1);
  localparam logic [23:0] HOLD_LAST = TIMEOUT - 24'd1;

  state_t      r_state;
  logic [1:0]  r_ptr;
  logic [1:0]  r_owner;
  logic [2:0]  r_gnt;
  logic [23:0] r_hold_cnt;
  logic [3:0]  r_turn_cnt;
  logic        r_to_pulse;
  logic        r_to_sts;
  pins_t       r_pins;

  pins_t       w_own_pins;
  logic        w_own_req;
  logic        w_own_done;
  logic        w_win_vld;
  logic [1:0]  w_win;
  logic [1:0]  w_next_ptr;
  logic        w_rel_norm;
  logic        w_to_hit;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_own_pins = '{a: bus.m_A[24:0], dq_o: bus.m_dq_o[15:0], dqe: bus.m_dqe[0],
                   oe: bus.m_oe[0], ce: bus.m_ce[0], we: bus.m_we[0], adv: bus.m_adv[0],
                   wp: bus.m_wp[0], rst_f: bus.m_rst_f[0]};
    w_own_req  = bus.req[0];
    w_own_done = bus.done[0];
    case (r_owner)
      2'd1: begin
        w_own_pins = '{a: bus.m_A[49:25], dq_o: bus.m_dq_o[31:16], dqe: bus.m_dqe[1],
                       oe: bus.m_oe[1], ce: bus.m_ce[1], we: bus.m_we[1], adv: bus.m_adv[1],
                       wp: bus.m_wp[1], rst_f: bus.m_rst_f[1]};
        w_own_req  = bus.req[1];
        w_own_done = bus.done[1];
      end
      2'd2: begin
        w_own_pins = '{a: bus.m_A[74:50], dq_o: bus.m_dq_o[47:32], dqe: bus.m_dqe[2],
                       oe: bus.m_oe[2], ce: bus.m_ce[2], we: bus.m_we[2], adv: bus.m_adv[2],
                       wp: bus.m_wp[2], rst_f: bus.m_rst_f[2]};
        w_own_req  = bus.req[2];
        w_own_done = bus.done[2];
      end
      default: ;
    endcase
  end

  // First set request at or above ptr, wrapping modulo 3.
  always_comb begin
    w_win_vld = |bus.req;
    case (r_ptr)
      2'd1:    w_win = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
      2'd2:    w_win = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
      default: w_win = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
    endcase
    w_next_ptr = (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
  end

  // A voluntary release always wins over a coincident watchdog expiry.
  assign w_rel_norm = w_own_done || !w_own_req;
  assign w_to_hit   = (r_hold_cnt == HOLD_LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= 2'd0;
      r_owner    <= 2'd0;
      r_gnt      <= 3'b000;
      r_hold_cnt <= '0;
      r_turn_cnt <= '0;
      r_to_pulse <= 1'b0;
      r_to_sts   <= 1'b0;
      r_pins     <= PINS_RESET;
    end else begin
      r_to_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pins <= PINS_IDLE;
          if (w_win_vld) begin
            r_state    <= S_HOLD;
            r_owner    <= w_win;
            r_gnt      <= 3'b001 << w_win;
            r_ptr      <= w_next_ptr;
            r_hold_cnt <= '0;
          end
        end
        S_HOLD: begin
          if (w_rel_norm || w_to_hit) begin
            r_state    <= S_RELEASE;
            r_gnt      <= 3'b000;
            r_pins     <= PINS_IDLE;
            r_turn_cnt <= TURN_LAST;
            if (!w_rel_norm) begin
              r_to_pulse <= 1'b1;
              r_to_sts   <= 1'b1;
            end
          end else begin
            r_pins <= w_own_pins;
            if (r_hold_cnt != '1) r_hold_cnt <= r_hold_cnt + 24'd1;
          end
        end
        S_RELEASE: begin
          r_pins <= PINS_IDLE;
          if (r_turn_cnt == 4'd0) r_state <= S_IDLE;
          else                    r_turn_cnt <= r_turn_cnt - 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.F_A      = r_pins.a;
  assign bus.F_dq_o   = r_pins.dq_o;
  assign bus.F_dqe    = r_pins.dqe;
  assign bus.F_oe     = r_pins.oe;
  assign bus.F_ce     = r_pins.ce;
  assign bus.F_we     = r_pins.we;
  assign bus.F_adv    = r_pins.adv;
  assign bus.F_wp     = r_pins.wp;
  assign bus.F_rst_f  = r_pins.rst_f;
  assign bus.dq_i     = bus.F_dq_i;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.to_pulse = r_to_pulse;
  assign bus.to_sts   = r_to_sts;

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Scenario bench for flash_bus_arbiter: expected grants are queued when requests
// are driven and a monitor pops them as grants appear, checking owner and gap.
module tb_flash_bus_arbiter;

  localparam int TURN_P = 2;

  typedef struct {
    logic [2:0] gnt;
    int         gap;  // expected idle samples before this grant, -1 = unchecked
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic [24:0] a_tab [3];
  logic [15:0] d_tab [3];

  flash_bus_arbiter_if bus ();

  flash_bus_arbiter #(.TURN(TURN_P), .TIMEOUT(24'd100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_m();
    bus.m_A    = {a_tab[2], a_tab[1], a_tab[0]};
    bus.m_dq_o = {d_tab[2], d_tab[1], d_tab[0]};
  endtask

  task automatic wait_gnt(input int budget);
    int n = 0;
    while (bus.gnt == 3'b000 && n < budget) begin
      step();
      n++;
    end
    n_vec++;
    if (bus.gnt == 3'b000) begin
      n_err++;
      $display("FAIL wait_gnt: no grant within %0d cycles", budget);
    end
  endtask

  // Grant monitor: pops one expectation per rising grant.
  initial begin
    logic [2:0] prev = 3'b000;
    int gap = 0;
    exp_t e;
    forever begin
      step();
      if (bus.gnt != 3'b000 && prev == 3'b000) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got gnt=%b, none expected", bus.gnt);
        end else begin
          e = exp_q.pop_front();
          if (bus.gnt !== e.gnt) begin
            n_err++;
            $display("FAIL sb_order: got gnt=%b, want %b", bus.gnt, e.gnt);
          end
          if (e.gap >= 0) begin
            n_vec++;
            if (gap != e.gap) begin
              n_err++;
              $display("FAIL sb_gap: got %0d idle cycles, want %0d", gap, e.gap);
            end
          end
        end
      end
      gap  = (bus.gnt == 3'b000) ? gap + 1 : 0;
      prev = bus.gnt;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_vec++;
    if (bus.gnt !== 3'b000 || bus.busy !== 1'b0 || bus.to_pulse !== 1'b0 || bus.to_sts !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctl: gnt=%b busy=%b to_pulse=%b to_sts=%b, want 000 0 0 0",
               bus.gnt, bus.busy, bus.to_pulse, bus.to_sts);
    end
    n_vec++;
    if ({bus.F_ce, bus.F_oe, bus.F_we, bus.F_adv, bus.F_dqe, bus.F_wp, bus.F_rst_f} !== 7'b1111000 ||
        bus.F_A !== 25'd0 || bus.F_dq_o !== 16'd0) begin
      n_err++;
      $display("FAIL reset_pins: ce,oe,we,adv,dqe,wp,rst_f=%b A=%h dq=%h, want 1111000 0 0",
               {bus.F_ce, bus.F_oe, bus.F_we, bus.F_adv, bus.F_dqe, bus.F_wp, bus.F_rst_f},
               bus.F_A, bus.F_dq_o);
    end
    bus.F_dq_i = 16'hBEEF;
    #1;
    n_vec++;
    if (bus.dq_i !== 16'hBEEF) begin
      n_err++;
      $display("FAIL dq_fanout: got %h, want beef", bus.dq_i);
    end
    rst_n = 1'b1;
    step();
    n_vec++;
    if (bus.F_wp !== 1'b1 || bus.F_rst_f !== 1'b1 || bus.gnt !== 3'b000) begin
      n_err++;
      $display("FAIL first_idle: wp=%b rst_f=%b gnt=%b, want 1 1 000", bus.F_wp, bus.F_rst_f, bus.gnt);
    end
  endtask

  task automatic test_basic_grant();
    step();
    exp_q.push_back('{gnt: 3'b100, gap: -1});
    bus.req = 3'b100;
    step();
    n_vec++;
    if (bus.gnt !== 3'b100 || bus.busy !== 1'b1 || bus.F_ce !== 1'b1) begin
      n_err++;
      $display("FAIL grant_latency: gnt=%b busy=%b F_ce=%b, want 100 1 1", bus.gnt, bus.busy, bus.F_ce);
    end
    step();
    n_vec++;
    if (bus.F_ce !== bus.m_ce[2] || bus.F_A !== a_tab[2] || bus.F_dq_o !== d_tab[2] ||
        bus.F_we !== bus.m_we[2] || bus.F_dqe !== bus.m_dqe[2]) begin
      n_err++;
      $display("FAIL pin_drive: ce=%b A=%h dq=%h, want %b %h %h",
               bus.F_ce, bus.F_A, bus.F_dq_o, bus.m_ce[2], a_tab[2], d_tab[2]);
    end
    a_tab[2] = 25'h0F0F0F2;
    load_m();
    step();
    n_vec++;
    if (bus.F_A !== 25'h0F0F0F2) begin
      n_err++;
      $display("FAIL pin_track: F_A=%h, want 0f0f0f2", bus.F_A);
    end
    bus.done = 3'b100;
    step();
    bus.done = 3'b000;
    bus.req  = 3'b000;
    n_vec++;
    if (bus.gnt !== 3'b000 || bus.F_ce !== 1'b1 || bus.F_A !== 25'd0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL done_release: gnt=%b ce=%b A=%h busy=%b, want 000 1 0 1",
               bus.gnt, bus.F_ce, bus.F_A, bus.busy);
    end
    repeat (3) step();
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL back_to_idle: busy=%b, want 0", bus.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] g;
    exp_q.push_back('{gnt: 3'b001, gap: -1});
    exp_q.push_back('{gnt: 3'b010, gap: TURN_P + 1});
    exp_q.push_back('{gnt: 3'b100, gap: TURN_P + 1});
    exp_q.push_back('{gnt: 3'b001, gap: TURN_P + 1});
    bus.req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(20);
      g = bus.gnt;
      repeat (10) step();
      n_vec++;
      if ((g == 3'b001 && bus.F_A !== a_tab[0]) || (g == 3'b010 && bus.F_A !== a_tab[1]) ||
          (g == 3'b100 && bus.F_A !== a_tab[2])) begin
        n_err++;
        $display("FAIL rr_pins: owner %b F_A=%h", g, bus.F_A);
      end
      repeat (9) step();
      bus.done = g;
      if (i == 3) bus.req = 3'b000;
      step();
      bus.done = 3'b000;
      for (int k = 0; k < TURN_P + 1; k++) begin
        n_vec++;
        if (bus.gnt !== 3'b000 || bus.F_ce !== 1'b1) begin
          n_err++;
          $display("FAIL rr_gap: idle cycle %0d gnt=%b F_ce=%b, want 000 1", k, bus.gnt, bus.F_ce);
        end
        if (k < TURN_P) step();
      end
    end
    repeat (3) step();
  endtask

  task automatic test_req_drop();
    exp_q.push_back('{gnt: 3'b001, gap: -1});
    bus.req = 3'b001;
    wait_gnt(10);
    repeat (5) step();
    bus.req = 3'b000;
    step();
    n_vec++;
    if (bus.gnt !== 3'b000 || bus.F_ce !== 1'b1 || bus.to_pulse !== 1'b0 || bus.to_sts !== 1'b0) begin
      n_err++;
      $display("FAIL drop_release: gnt=%b ce=%b to_pulse=%b to_sts=%b, want 000 1 0 0",
               bus.gnt, bus.F_ce, bus.to_pulse, bus.to_sts);
    end
    step();
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL drop_turn: busy=%b, want 1", bus.busy);
    end
    step();
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL drop_idle: busy=%b, want 0", bus.busy);
    end
    step();
  endtask

  task automatic test_done_at_timeout();
    exp_q.push_back('{gnt: 3'b001, gap: -1});
    bus.req = 3'b001;
    wait_gnt(10);
    repeat (99) step();
    bus.done = 3'b001;
    step();
    bus.done = 3'b000;
    bus.req  = 3'b000;
    n_vec++;
    if (bus.gnt !== 3'b000 || bus.to_pulse !== 1'b0 || bus.to_sts !== 1'b0) begin
      n_err++;
      $display("FAIL done_vs_timeout: gnt=%b to_pulse=%b to_sts=%b, want 000 0 0",
               bus.gnt, bus.to_pulse, bus.to_sts);
    end
    repeat (4) step();
  endtask

  task automatic test_timeout();
    exp_q.push_back('{gnt: 3'b010, gap: -1});
    exp_q.push_back('{gnt: 3'b100, gap: TURN_P + 1});
    bus.req = 3'b110;
    wait_gnt(10);
    repeat (99) step();
    n_vec++;
    if (bus.gnt !== 3'b010 || bus.to_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL to_early: gnt=%b to_pulse=%b, want 010 0", bus.gnt, bus.to_pulse);
    end
    step();
    bus.req = 3'b100;
    n_vec++;
    if (bus.gnt !== 3'b000 || bus.to_pulse !== 1'b1 || bus.to_sts !== 1'b1 || bus.F_ce !== 1'b1) begin
      n_err++;
      $display("FAIL to_reclaim: gnt=%b to_pulse=%b to_sts=%b ce=%b, want 000 1 1 1",
               bus.gnt, bus.to_pulse, bus.to_sts, bus.F_ce);
    end
    step();
    n_vec++;
    if (bus.to_pulse !== 1'b0 || bus.to_sts !== 1'b1) begin
      n_err++;
      $display("FAIL to_pulse_width: to_pulse=%b to_sts=%b, want 0 1", bus.to_pulse, bus.to_sts);
    end
    wait_gnt(10);
    bus.done = 3'b100;
    bus.req  = 3'b000;
    step();
    bus.done = 3'b000;
    repeat (4) step();
    n_vec++;
    if (bus.to_sts !== 1'b1) begin
      n_err++;
      $display("FAIL to_sticky: to_sts=%b, want 1", bus.to_sts);
    end
  endtask

  task automatic test_reset_mid_hold();
    exp_q.push_back('{gnt: 3'b010, gap: -1});
    bus.req = 3'b010;
    wait_gnt(10);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    n_vec++;
    if (bus.gnt !== 3'b000 || bus.F_ce !== 1'b1 || bus.F_rst_f !== 1'b0 || bus.F_wp !== 1'b0 ||
        bus.busy !== 1'b0 || bus.to_sts !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: gnt=%b ce=%b rst_f=%b wp=%b busy=%b to_sts=%b, want 000 1 0 0 0 0",
               bus.gnt, bus.F_ce, bus.F_rst_f, bus.F_wp, bus.busy, bus.to_sts);
    end
    step();
    exp_q.push_back('{gnt: 3'b010, gap: -1});
    rst_n   = 1'b1;
    bus.req = 3'b110;
    step();
    n_vec++;
    if (bus.gnt !== 3'b010 || bus.F_rst_f !== 1'b1) begin
      n_err++;
      $display("FAIL ptr_after_reset: gnt=%b rst_f=%b, want 010 1", bus.gnt, bus.F_rst_f);
    end
    bus.done = 3'b010;
    bus.req  = 3'b000;
    step();
    bus.done = 3'b000;
    repeat (4) step();
    n_vec++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL sb_drain: %0d grants outstanding, busy=%b, want 0 0", exp_q.size(), bus.busy);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.req     = 3'b000;
    bus.done    = 3'b000;
    a_tab[0]    = 25'h0123400;
    a_tab[1]    = 25'h0555501;
    a_tab[2]    = 25'h1ABCDE2;
    d_tab[0]    = 16'hA0A0;
    d_tab[1]    = 16'hB1B1;
    d_tab[2]    = 16'hC2C2;
    load_m();
    bus.m_dqe   = 3'b101;
    bus.m_oe    = 3'b010;
    bus.m_ce    = 3'b011;
    bus.m_we    = 3'b110;
    bus.m_adv   = 3'b001;
    bus.m_wp    = 3'b111;
    bus.m_rst_f = 3'b111;
    bus.F_dq_i  = 16'h0000;
    test_reset();
    test_basic_grant();
    test_round_robin();
    test_req_drop();
    test_done_at_timeout();
    test_timeout();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
